counter_ud_mod: RTL and testbench

Parametrised up/down counter. It is the next generation of the team's 4-bit load/up/down counter with rollover. Adds the following:
- Runtime modulus (limit)
- Programmable step
- Count enable
- Wrap or saturate mode
- Separate rollover and rollunder pulses
- Sticky overflow flag
Used as a general event/timer counter behind a cnt_if-style interface in block-level benches.

---
 rtl/counter_ud_mod.sv | 101 ++++++++++
 tb/tb_counter_ud_mod.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_ud_mod.sv
// Parametrised up/down counter with runtime modulus, programmable step,
// wrap/saturate mode, registered rollover/rollunder pulses and a sticky overflow flag.
module counter_ud_mod #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    input  logic              clr_sticky,
    output logic [WIDTH-1:0]  count,
    output logic              rollover,
    output logic              rollunder,
    output logic              at_max,
    output logic              at_zero,
    output logic              ovf_sticky
);

    // One guard bit so sums and modulus (limit+1) never truncate before compare.
    localparam int XW = WIDTH + 1;
    typedef logic [XW-1:0] ext_t;

    logic [WIDTH-1:0] count_q, count_d;
    logic             rollover_q, rollover_d;
    logic             rollunder_q, rollunder_d;
    logic             sticky_q, sticky_d;

    ext_t lim_x, cnt_x, load_x, stp_x, s_x, mod_x, sum_x, next_x;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        lim_x       = {1'b0, limit};
        cnt_x       = {1'b0, count_q};
        load_x      = {1'b0, load};
        stp_x       = XW'(step);
        s_x         = (stp_x > lim_x) ? lim_x : stp_x;
        mod_x       = lim_x + ext_t'(1);
        sum_x       = cnt_x + s_x;
        next_x      = cnt_x;
        rollover_d  = 1'b0;
        rollunder_d = 1'b0;

        if (load_en) begin
            next_x = (load_x > lim_x) ? lim_x : load_x;
        end else if (en) begin
            if (cnt_x > lim_x) begin
                // Limit was lowered below the count: pull back in range, ignore step.
                next_x = lim_x;
            end else if (s_x != '0) begin
                if (!down) begin
                    if (sum_x > lim_x) begin
                        rollover_d = 1'b1;
                        next_x     = sat_mode ? lim_x : (sum_x - mod_x);
                    end else begin
                        next_x = sum_x;
                    end
                end else begin
                    if (cnt_x >= s_x) begin
                        next_x = cnt_x - s_x;
                    end else begin
                        rollunder_d = 1'b1;
                        next_x      = sat_mode ? '0 : (cnt_x + mod_x - s_x);
                    end
                end
            end
        end

        count_d  = next_x[WIDTH-1:0];
        // Set has priority over clear when an event lands on a clearing cycle.
        sticky_d = rollover_d | rollunder_d | (sticky_q & ~clr_sticky);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= '0;
            rollover_q  <= 1'b0;
            rollunder_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            rollover_q  <= rollover_d;
            rollunder_q <= rollunder_d;
            sticky_q    <= sticky_d;
        end
    end

    assign count      = count_q;
    assign rollover   = rollover_q;
    assign rollunder  = rollunder_q;
    assign ovf_sticky = sticky_q;
    assign at_max     = (count_q == limit);
    assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod: directed literal scenarios plus
// randomized stimulus against an integer-arithmetic reference model.
module tb_counter_ud_mod;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic              load_en = 1'b0;
    logic [WIDTH-1:0]  load = '0;
    logic              down = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic [WIDTH-1:0]  limit = '0;
    logic              sat_mode = 1'b0;
    logic              clr_sticky = 1'b0;
    logic [WIDTH-1:0]  count;
    logic              rollover, rollunder, at_max, at_zero, ovf_sticky;

    int checks = 0;
    int failures = 0;

    counter_ud_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .rstn(rstn), .en(en), .load_en(load_en), .load(load),
        .down(down), .step(step), .limit(limit), .sat_mode(sat_mode),
        .clr_sticky(clr_sticky), .count(count), .rollover(rollover),
        .rollunder(rollunder), .at_max(at_max), .at_zero(at_zero),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the documented rules.
    int m_count = 0;
    bit m_ro = 0, m_ru = 0, m_st = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_count = 0; m_ro = 0; m_ru = 0; m_st = 0;
        end else begin
            int lim, c, s;
            bit ro, ru;
            lim = int'(limit);
            c   = m_count;
            s   = (int'(step) < lim) ? int'(step) : lim;
            ro  = 0;
            ru  = 0;
            if (load_en) begin
                c = (int'(load) < lim) ? int'(load) : lim;
            end else if (en) begin
                if (c > lim) c = lim;
                else if (s > 0) begin
                    if (!down) begin
                        if (c + s > lim) begin
                            ro = 1;
                            c  = sat_mode ? lim : c + s - (lim + 1);
                        end else c = c + s;
                    end else begin
                        if (c >= s) c = c - s;
                        else begin
                            ru = 1;
                            c  = sat_mode ? 0 : c + (lim + 1) - s;
                        end
                    end
                end
            end
            m_count = c;
            m_ro    = ro;
            m_ru    = ru;
            m_st    = ro | ru | (m_st & !clr_sticky);
        end
    end

    // Compare process: outputs are stable mid-cycle, inputs change at posedge+2.
    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_count", int'(count), m_count);
            check("m_rollover", int'(rollover), int'(m_ro));
            check("m_rollunder", int'(rollunder), int'(m_ru));
            check("m_sticky", int'(ovf_sticky), int'(m_st));
            check("m_at_max", int'(at_max), int'(m_count == int'(limit)));
            check("m_at_zero", int'(at_zero), int'(m_count == 0));
            if (rollover && rollunder) check("both_pulses", 1, 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string name, input int c, input int ro, input int ru, input int st);
        check({name, "_count"}, int'(count), c);
        check({name, "_ro"}, int'(rollover), ro);
        check({name, "_ru"}, int'(rollunder), ru);
        check({name, "_sticky"}, int'(ovf_sticky), st);
    endtask

    task automatic do_load(input int v);
        load_en = 1'b1; load = WIDTH'(v);
        cyc();
        load_en = 1'b0;
    endtask

    initial begin
        #12;
        expect_state("in_reset", 0, 0, 0, 0);
        rstn = 1'b1;
        cmp_on = 1;

        // 1: reset mid-count takes effect immediately
        limit = 15; do_load(9);
        expect_state("t1_load", 9, 0, 0, 0);
        #2 rstn = 1'b0;
        #1 expect_state("t1_async_rst", 0, 0, 0, 0);
        check("t1_at_zero", int'(at_zero), 1);
        cyc();
        rstn = 1'b1; en = 1'b1; step = 1; down = 1'b0; sat_mode = 1'b0;
        cyc(); check("t1_c1", int'(count), 1);
        cyc(); check("t1_c2", int'(count), 2);
        cyc(); check("t1_c3", int'(count), 3);

        // 2: wrap up with step 3, limit 9
        en = 1'b0; limit = 9; step = 3; do_load(6);
        en = 1'b1;
        cyc(); expect_state("t2_9", 9, 0, 0, 0);
        check("t2_at_max", int'(at_max), 1);
        cyc(); expect_state("t2_2", 2, 1, 0, 1);
        cyc(); expect_state("t2_5", 5, 0, 0, 1);
        cyc(); expect_state("t2_8", 8, 0, 0, 1);
        cyc(); expect_state("t2_1", 1, 1, 0, 1);

        // 3: down wrap then saturate, step 2
        en = 1'b0; step = 2; down = 1'b1; do_load(1);
        en = 1'b1;
        cyc(); check("t3w_9", int'(count), 9); check("t3w_ru", int'(rollunder), 1);
        cyc(); check("t3w_7", int'(count), 7); check("t3w_ru0", int'(rollunder), 0);
        en = 1'b0; sat_mode = 1'b1; do_load(1);
        en = 1'b1;
        cyc(); check("t3s_0a", int'(count), 0); check("t3s_ru_a", int'(rollunder), 1);
        cyc(); check("t3s_0b", int'(count), 0); check("t3s_ru_b", int'(rollunder), 1);

        // 4: load priority and clamp
        sat_mode = 1'b0; down = 1'b0; step = 1; en = 1'b1;
        load_en = 1'b1; load = 12;
        cyc(); load_en = 1'b0;
        check("t4_clamp", int'(count), 9);
        check("t4_no_ro", int'(rollover), 0);
        cyc(); check("t4_wrap", int'(count), 0); check("t4_ro", int'(rollover), 1);

        // 5: limit lowered below count
        en = 1'b0; do_load(8);
        limit = 5; en = 1'b1;
        cyc(); check("t5_clamp", int'(count), 5); check("t5_no_ro", int'(rollover), 0);
        cyc(); check("t5_wrap", int'(count), 0); check("t5_ro", int'(rollover), 1);

        // 6: sticky clear vs set
        en = 1'b0; clr_sticky = 1'b1;
        cyc(); check("t6_cleared", int'(ovf_sticky), 0);
        clr_sticky = 1'b0; do_load(5);
        en = 1'b1; clr_sticky = 1'b1;
        cyc(); check("t6_set_wins", int'(ovf_sticky), 1); check("t6_ro", int'(rollover), 1);
        clr_sticky = 1'b0;

        // limit 0: enabled steps hold at 0
        limit = 0; en = 1'b1; step = 3;
        cyc(); cyc();
        check("lim0_count", int'(count), 0); check("lim0_ro", int'(rollover), 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            limit      = (r == 0) ? 4'd15 : (r == 1) ? 4'd0 : WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0 && i > 0) limit = limit; // keep random pick
            en         = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 15) == 0);
            load       = WIDTH'($urandom);
            down       = $urandom_range(0, 1);
            step       = STEP_W'($urandom);
            sat_mode   = ($urandom_range(0, 3) == 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                #1 rstn = 1'b1;
            end
            cyc();
        end

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
